tp_dis_loader: RTL and testbench

TP_DIS_LOADER -- requirements
Module: tp_dis_loader

---
 rtl/tp_dis_loader.sv | 143 ++++++++++++++
 tb/tb_tp_dis_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tp_dis_loader.sv
// Distance-table loader: clears the diagonal, then writes each host
// upper-triangle beat to {r,c} and its mirror {c,r} in the node array.
package replica_pkg;
  localparam int city_num     = 4;
  localparam int city_num_log = 2;
  typedef logic [15:0] distance_data_t;
endpackage

module tp_dis_loader
  import replica_pkg::*;
#(
  parameter int CITY_NUM = city_num,
  parameter int CITY_LOG = city_num_log
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    s_valid,
  input  distance_data_t          s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    tp_dis_write,
  output logic [CITY_LOG*2-1:0]   tp_dis_waddr,
  output distance_data_t          tp_dis_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    MIRROR,
    DONE
  } state_t;

  localparam logic [CITY_LOG-1:0] LAST_R = CITY_LOG'(CITY_NUM - 2);
  localparam logic [CITY_LOG-1:0] LAST_C = CITY_LOG'(CITY_NUM - 1);

  state_t                 r_state;
  logic [CITY_LOG-1:0]    r_row;
  logic [CITY_LOG-1:0]    r_col;
  logic [CITY_LOG-1:0]    r_k;
  logic                   r_last;
  logic                   r_write;
  logic [CITY_LOG*2-1:0]  r_waddr;
  distance_data_t         r_wdata;
  logic                   r_done;
  logic                   r_err;
  logic                   w_is_last;

  assign w_is_last    = (r_row == LAST_R) && (r_col == LAST_C);
  assign s_ready      = (r_state == LOAD);
  assign busy         = (r_state != IDLE);
  assign tp_dis_write = r_write;
  assign tp_dis_waddr = r_waddr;
  assign tp_dis_wdata = r_wdata;
  assign done         = r_done;
  assign err          = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_last  <= 1'b0;
      r_write <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_write <= 1'b0;
          r_done  <= 1'b0;
          // The k=0 diagonal write is issued on the start edge itself
          if (start) begin
            r_err   <= 1'b0;
            r_row   <= '0;
            r_col   <= CITY_LOG'(1);
            r_k     <= CITY_LOG'(1);
            r_last  <= 1'b0;
            r_write <= 1'b1;
            r_waddr <= '0;
            r_wdata <= '0;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_write <= 1'b1;
          r_waddr <= {r_k, r_k};
          r_wdata <= '0;
          if (r_k == LAST_C) begin
            r_state <= LOAD;
          end else begin
            r_k <= r_k + CITY_LOG'(1);
          end
        end
        LOAD: begin
          r_write <= 1'b0;
          if (s_valid) begin
            r_write <= 1'b1;
            r_waddr <= {r_row, r_col};
            r_wdata <= s_data;
            r_last  <= w_is_last;
            if (s_last != w_is_last) begin
              r_err <= 1'b1;
            end
            // Compare before increment so the index never wraps
            if (!w_is_last) begin
              if (r_col != LAST_C) begin
                r_col <= r_col + CITY_LOG'(1);
              end else begin
                r_row <= r_row + CITY_LOG'(1);
                r_col <= r_row + CITY_LOG'(2);
              end
            end
            r_state <= MIRROR;
          end
        end
        MIRROR: begin
          r_write <= 1'b1;
          r_waddr <= {r_waddr[CITY_LOG-1:0],
                      r_waddr[CITY_LOG*2-1:CITY_LOG]};
          r_state <= r_last ? DONE : LOAD;
        end
        DONE: begin
          r_write <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_write <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tp_dis_loader.sv
// Directed bench for tp_dis_loader with N=4: full load, backpressure,
// s_last mismatch, ignored start, mid-load reset and idle s_valid.
module tb_tp_dis_loader;
  import replica_pkg::*;

  logic           clk;
  logic           reset;
  logic           start;
  logic           s_valid;
  distance_data_t s_data;
  logic           s_last;
  logic           s_ready;
  logic           tp_dis_write;
  logic [3:0]     tp_dis_waddr;
  distance_data_t tp_dis_wdata;
  logic           busy;
  logic           done;
  logic           err;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  logic [19:0] wlog[$];
  logic [19:0] exp_wr[16];
  distance_data_t dv[6];

  tp_dis_loader #(.CITY_NUM(4), .CITY_LOG(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .tp_dis_write (tp_dis_write),
    .tp_dis_waddr (tp_dis_waddr),
    .tp_dis_wdata (tp_dis_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tp_dis_write) wlog.push_back({tp_dis_waddr, tp_dis_wdata});
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Holds s_valid high; returns 1 time unit after the accepting edge
  task automatic send(input distance_data_t d, input logic last,
                      output int waits);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    waits   = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ok) begin
        @(negedge clk);
        if (s_ready) begin
          @(posedge clk);
          #1 ok = 1'b1;
        end else begin
          waits++;
        end
      end
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        @(negedge clk);
        seen = done;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nwr"}, 32'(wlog.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wlog.size()) chk($sformatf("%s_w%0d", tag, i),
                               32'(wlog[i]), 32'(exp_wr[i]));
    end
    chk({tag, "_ndone"}, 32'(n_done), 32'd1);
  endtask

  int w;

  initial begin
    dv = '{16'h1A01, 16'h2B02, 16'h3C03, 16'h4D04, 16'h5E05, 16'h6F06};
    exp_wr = '{20'h0_0000, 20'h5_0000, 20'hA_0000, 20'hF_0000,
               20'h1_1A01, 20'h4_1A01, 20'h2_2B02, 20'h8_2B02,
               20'h3_3C03, 20'hC_3C03, 20'h6_4D04, 20'h9_4D04,
               20'h7_5E05, 20'hD_5E05, 20'hB_6F06, 20'hE_6F06};
    reset = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_write", 32'(tp_dis_write), 32'd0);
    chk("rst_waddr", 32'(tp_dis_waddr), 32'd0);
    chk("rst_wdata", 32'(tp_dis_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // s_valid in IDLE without start
    s_valid = 1'b1;
    s_data = 16'hDEAD;
    repeat (4) @(negedge clk);
    chk("idle_ready", 32'(s_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_nwr", 32'(wlog.size()), 32'd0);
    s_valid = 1'b0;

    // full load, s_valid held continuously
    wlog.delete();
    n_done = 0;
    pulse_start();
    @(negedge clk);
    chk("clr0_write", 32'(tp_dis_write), 32'd1);
    chk("clr0_addr", 32'(tp_dis_waddr), 32'h0);
    chk("clr0_busy", 32'(busy), 32'd1);
    chk("clr_ready", 32'(s_ready), 32'd0);
    send(dv[0], 1'b0, w);
    chk("b1_waits", 32'(w), 32'd2);
    for (int i = 1; i < 6; i++) begin
      send(dv[i], 1'(i == 5), w);
      chk($sformatf("b%0d_waits", i + 1), 32'(w), 32'd1);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    @(negedge clk);
    chk("last_addr", 32'(tp_dis_waddr), 32'hB);
    @(negedge clk);
    chk("mir_addr", 32'(tp_dis_waddr), 32'hE);
    chk("mir_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_write", 32'(tp_dis_write), 32'd0);
    @(negedge clk);
    chk("done_clr", 32'(done), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("full_err", 32'(err), 32'd0);
    check_log("full");

    // s_last on beat 3 and not on beat 6
    wlog.delete();
    n_done = 0;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send(dv[i], 1'(i == 2), w);
      if (i == 2) chk("err_set", 32'(err), 32'd1);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    wait_done();
    chk("err_sticky", 32'(err), 32'd1);
    check_log("lasterr");

    // next start clears err; start pulsed mid-load is ignored
    wlog.delete();
    n_done = 0;
    pulse_start();
    @(negedge clk);
    chk("err_clr", 32'(err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) start = 1'b1;
      send(dv[i], 1'(i == 5), w);
      start = 1'b0;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    wait_done();
    chk("ign_err", 32'(err), 32'd0);
    check_log("ignstart");

    // reset while in MIRROR after beat 2
    wlog.delete();
    pulse_start();
    send(dv[0], 1'b0, w);
    send(dv[1], 1'b0, w);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mrst_write", 32'(tp_dis_write), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_nwr", 32'(wlog.size()), 32'd7);
    if (wlog.size() > 6) chk("mrst_lastw", 32'(wlog[6]), 32'h2_2B02);
    chk("mrst_ready", 32'(s_ready), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);
    s_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
